// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream bundle carried from the pattern generator
// to the write master.
interface axis_pattern_gen_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;

  modport master (
    output tvalid, tdata, tstrb, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tlast,
    output tready
  );
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern source: NBURST bursts of
// BURST_LENGTH+1 beats, with stall and beat counters.
module axis_pattern_gen #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               START_REG,
  input  logic [31:0]        NBURST_REG,
  input  logic [1:0]         MODE_REG,
  input  logic [31:0]        SEED_REG,
  axis_pattern_gen_if.master m_axis,
  output logic               trigger,
  output logic               busy,
  output logic               done,
  output logic [31:0]        STALL_CNT_REG,
  output logic [31:0]        BEAT_CNT_REG
);
  localparam int          LANES = DATA_WIDTH / 32;
  localparam logic [31:0] POLY  = 32'h8020_0003;
  localparam logic [31:0] BLAST = 32'(BURST_LENGTH);

  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, DONE_ST
  } state_e;

  state_e state_q, state_d;

  logic [31:0] nburst_q, nburst_d;
  logic [31:0] seed_q, seed_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] stall_q, stall_d;

  logic                  valid;
  logic                  hs;
  logic                  last_beat;
  logic                  last_burst;
  logic [31:0]           word;
  logic [DATA_WIDTH-1:0] pat;

  assign hs         = valid & m_axis.tready;
  assign last_beat  = (beat_q == BLAST);
  assign last_burst = (burst_q == nburst_q - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // An abort waits for the pending beat, so it shares the hs path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (START_REG) state_d = LOAD;
      LOAD:
        state_d = (NBURST_REG == '0) ? DONE_ST : RUN;
      RUN:
        if (hs) begin
          if (!START_REG)
            state_d = IDLE;
          else if (last_beat && last_burst)
            state_d = DONE_ST;
        end
      DONE_ST:
        if (!START_REG) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    valid   = 1'b0;
    trigger = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      LOAD: begin
        trigger = 1'b1;
        busy    = 1'b1;
      end
      RUN: begin
        valid   = 1'b1;
        trigger = 1'b1;
        busy    = 1'b1;
      end
      DONE_ST: begin
        trigger = 1'b1;
        busy    = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    nburst_d = nburst_q;
    seed_d   = seed_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    beats_d  = beats_q;
    stall_d  = stall_q;
    if (state_q == LOAD) begin
      nburst_d = NBURST_REG;
      seed_d   = SEED_REG;
      mode_d   = MODE_REG;
      idx_d    = '0;
      lfsr_d   = (SEED_REG == '0) ? 32'd1 : SEED_REG;
      beat_d   = '0;
      burst_d  = '0;
      beats_d  = '0;
      stall_d  = '0;
    end else if (hs) begin
      idx_d   = idx_q + 32'd1;
      lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
      beats_d = beats_q + 32'd1;
      if (last_beat) begin
        beat_d  = '0;
        burst_d = burst_q + 32'd1;
      end else begin
        beat_d  = beat_q + 32'd1;
      end
    end else if (valid && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nburst_q <= '0;
      seed_q   <= '0;
      mode_q   <= '0;
      idx_q    <= '0;
      lfsr_q   <= '0;
      beat_q   <= '0;
      burst_q  <= '0;
      beats_q  <= '0;
      stall_q  <= '0;
    end else begin
      nburst_q <= nburst_d;
      seed_q   <= seed_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      beats_q  <= beats_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    word = seed_q + idx_q;
      2'd1:    word = lfsr_q;
      2'd2:    word = ~(seed_q + idx_q);
      default: word = seed_q;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign pat[32*k +: 32] = word ^ 32'(k);
  end

  assign m_axis.tvalid = valid;
  assign m_axis.tdata  = valid ? pat : '0;
  assign m_axis.tstrb  = {(DATA_WIDTH/8){valid}};
  assign m_axis.tlast  = valid & last_beat;

  assign STALL_CNT_REG = stall_q;
  assign BEAT_CNT_REG  = beats_q;
endmodule

// File: tb/tb_axis_pattern_gen.sv
// Randomized self-checking bench for axis_pattern_gen
// against a beat-list reference model.
module tb_axis_pattern_gen;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] nb_r;
  logic [1:0]  mode_r;
  logic [31:0] seed_r;
  logic        trigger;
  logic        busy;
  logic        done;
  logic [31:0] stall_cnt;
  logic [31:0] beat_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axis_pattern_gen_if #(.DATA_WIDTH(64)) ax ();

  axis_pattern_gen #(
    .DATA_WIDTH  (64),
    .BURST_LENGTH(7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .START_REG    (start),
    .NBURST_REG   (nb_r),
    .MODE_REG     (mode_r),
    .SEED_REG     (seed_r),
    .m_axis       (ax),
    .trigger      (trigger),
    .busy         (busy),
    .done         (done),
    .STALL_CNT_REG(stall_cnt),
    .BEAT_CNT_REG (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Galois LFSR over x^32+x^22+x^2+x+1 in right-shifting form.
  function automatic logic [31:0] lfsr_next(logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [63:0] exp_data(
    logic [1:0] m, logic [31:0] s, int unsigned i, logic [31:0] l);
    logic [31:0] w;
    case (m)
      2'd0:    w = s + 32'(i);
      2'd1:    w = l;
      2'd2:    w = ~(s + 32'(i));
      default: w = s;
    endcase
    return {w ^ 32'd1, w};
  endfunction

  // rmode: 0 always ready, 1 toggling 1-0-1-0, 2 random.
  task automatic do_run(input int nburst, input logic [1:0] m,
                        input logic [31:0] s, input int rmode,
                        input bit scramble, input string nm);
    logic [63:0] expd[$];
    bit          expl[$];
    logic [31:0] l;
    int          total;
    int          k;
    int          stalls;
    int          cyc;
    bit          rdy;
    total = nburst * 8;
    l = (s == 0) ? 32'd1 : s;
    for (int i = 0; i < total; i++) begin
      expd.push_back(exp_data(m, s, i, l));
      expl.push_back((i % 8) == 7);
      l = lfsr_next(l);
    end
    nb_r   = 32'(nburst);
    mode_r = m;
    seed_r = s;
    start  = 1'b1;
    ax.tready = 1'b0;
    step();
    total_cnt++;
    if (ax.tvalid !== 1'b0 || trigger !== 1'b1)
      $display("FAIL %s load: tvalid=%b trigger=%b want 0/1", nm, ax.tvalid, trigger);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ax.tvalid !== 1'b1)
      $display("FAIL %s first_valid: got %b want 1", nm, ax.tvalid);
    else pass_cnt++;
    if (scramble) begin
      nb_r   = $urandom;
      mode_r = 2'($urandom);
      seed_r = $urandom;
    end
    k = 0;
    stalls = 0;
    cyc = 0;
    while (k < total && cyc < 2000) begin
      total_cnt++;
      if (ax.tvalid !== 1'b1) begin
        $display("FAIL %s tvalid beat %0d: got %b want 1", nm, k, ax.tvalid);
        break;
      end else pass_cnt++;
      total_cnt++;
      if (ax.tdata !== expd[k])
        $display("FAIL %s tdata beat %0d: got %h want %h", nm, k, ax.tdata, expd[k]);
      else pass_cnt++;
      total_cnt++;
      if (ax.tlast !== expl[k] || ax.tstrb !== 8'hFF)
        $display("FAIL %s tlast/tstrb beat %0d: got %b/%h want %b/ff",
                 nm, k, ax.tlast, ax.tstrb, expl[k]);
      else pass_cnt++;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = $urandom_range(0, 3) != 0;
      endcase
      ax.tready = rdy;
      if (rdy) k++;
      else stalls++;
      step();
      cyc++;
    end
    ax.tready = 1'b0;
    total_cnt++;
    if (k != total)
      $display("FAIL %s beats_seen: got %0d want %0d", nm, k, total);
    else pass_cnt++;
    total_cnt++;
    if (ax.tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s end: tvalid=%b done=%b busy=%b want 0/1/1",
               nm, ax.tvalid, done, busy);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt !== 32'(total))
      $display("FAIL %s BEAT_CNT: got %0d want %0d", nm, beat_cnt, total);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 32'(stalls))
      $display("FAIL %s STALL_CNT: got %0d want %0d", nm, stall_cnt, stalls);
    else pass_cnt++;
    step();
    total_cnt++;
    if (done !== 1'b1 || ax.tvalid !== 1'b0)
      $display("FAIL %s done_hold: done=%b tvalid=%b want 1/0", nm, done, ax.tvalid);
    else pass_cnt++;
    start = 1'b0;
    step();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || trigger !== 1'b0)
      $display("FAIL %s idle: done=%b busy=%b trigger=%b want 0/0/0",
               nm, done, busy, trigger);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    nb_r = 0;
    mode_r = 0;
    seed_r = 0;
    ax.tready = 1'b0;
    step();
    step();
    total_cnt++;
    if ({ax.tvalid, ax.tlast, ax.tstrb, ax.tdata, trigger, busy, done,
         stall_cnt, beat_cnt} !== '0)
      $display("FAIL reset: tvalid=%b tdata=%h trig=%b busy=%b done=%b beats=%0d want all 0",
               ax.tvalid, ax.tdata, trigger, busy, done, beat_cnt);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_incr();
    do_run(2, 2'd0, 32'h100, 0, 1'b0, "incr");
  endtask

  task automatic test_backpressure();
    do_run(2, 2'd0, 32'h100, 1, 1'b0, "toggle");
  endtask

  task automatic test_lfsr();
    nb_r = 1;
    mode_r = 2'd1;
    seed_r = 0;
    start = 1'b1;
    ax.tready = 1'b0;
    step();
    step();
    total_cnt++;
    if (ax.tdata !== 64'h0000_0000_0000_0001)
      $display("FAIL lfsr_first: got %h want 0000000000000001", ax.tdata);
    else pass_cnt++;
    ax.tready = 1'b1;
    step();
    total_cnt++;
    if (ax.tdata !== 64'h8020_0002_8020_0003)
      $display("FAIL lfsr_second: got %h want 8020000280200003", ax.tdata);
    else pass_cnt++;
    start = 1'b0;
    step();
    total_cnt++;
    if (ax.tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL lfsr_abort: tvalid=%b busy=%b want 0/0", ax.tvalid, busy);
    else pass_cnt++;
    ax.tready = 1'b0;
    do_run(2, 2'd1, 32'h0, 2, 1'b0, "lfsr");
  endtask

  task automatic test_nburst0();
    nb_r = 0;
    mode_r = 0;
    seed_r = 32'h77;
    start = 1'b1;
    step();
    step();
    total_cnt++;
    if (ax.tvalid !== 1'b0 || done !== 1'b1 || trigger !== 1'b1 || beat_cnt !== 0)
      $display("FAIL nburst0: tvalid=%b done=%b trig=%b beats=%0d want 0/1/1/0",
               ax.tvalid, done, trigger, beat_cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (ax.tvalid !== 1'b0 || done !== 1'b1)
      $display("FAIL nburst0_hold: tvalid=%b done=%b want 0/1", ax.tvalid, done);
    else pass_cnt++;
    start = 1'b0;
    step();
    total_cnt++;
    if (done !== 1'b0 || trigger !== 1'b0)
      $display("FAIL nburst0_idle: done=%b trig=%b want 0/0", done, trigger);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [63:0] w5;
    w5 = exp_data(2'd0, 32'h1000, 5, 32'h0);
    nb_r = 4;
    mode_r = 0;
    seed_r = 32'h1000;
    start = 1'b1;
    ax.tready = 1'b1;
    step();
    step();
    repeat (5) step();
    ax.tready = 1'b0;
    start = 1'b0;
    total_cnt++;
    if (ax.tdata !== w5)
      $display("FAIL abort_beat5: got %h want %h", ax.tdata, w5);
    else pass_cnt++;
    repeat (3) begin
      step();
      total_cnt++;
      if (ax.tvalid !== 1'b1 || ax.tdata !== w5)
        $display("FAIL abort_hold: tvalid=%b tdata=%h want 1/%h", ax.tvalid, ax.tdata, w5);
      else pass_cnt++;
    end
    ax.tready = 1'b1;
    step();
    ax.tready = 1'b0;
    total_cnt++;
    if (ax.tvalid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || trigger !== 1'b0)
      $display("FAIL abort_idle: tvalid=%b done=%b busy=%b trig=%b want 0/0/0/0",
               ax.tvalid, done, busy, trigger);
    else pass_cnt++;
    total_cnt++;
    if (beat_cnt !== 32'd6 || stall_cnt !== 32'd3)
      $display("FAIL abort_counts: beats=%0d stalls=%0d want 6/3", beat_cnt, stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    nb_r = 2;
    mode_r = 0;
    seed_r = 32'h55;
    start = 1'b1;
    ax.tready = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    total_cnt++;
    if ({ax.tvalid, ax.tlast, ax.tstrb, ax.tdata, trigger, busy, done,
         stall_cnt, beat_cnt} !== '0)
      $display("FAIL reset_mid: tvalid=%b tdata=%h trig=%b busy=%b beats=%0d want all 0",
               ax.tvalid, ax.tdata, trigger, busy, beat_cnt);
    else pass_cnt++;
    rst = 1'b0;
    ax.tready = 1'b0;
    step();
    do_run(2, 2'd0, 32'h300, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      do_run($urandom_range(1, 3), 2'($urandom_range(0, 3)),
             $urandom, 2, 1'b1, "random");
  endtask

  task automatic test_back_to_back();
    do_run(1, 2'd3, 32'hCAFE_F00D, 2, 1'b0, "b2b_a");
    do_run(1, 2'd2, 32'hFFFF_FFFC, 0, 1'b0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_incr();
    test_backpressure();
    test_lfsr();
    test_nburst0();
    test_abort();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
